// File: rtl/execution_unit.sv
// execution_unit: integer ALU with iterative shift-add multiplier driving a registered forward bus
module execution_unit #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2*DATA_W+TAG_W+3:0]     inOperation,
    input  logic                          inOperationValid,
    output logic                          ready,
    output logic [DATA_W+TAG_W:0]         forward
);
    typedef enum logic {IDLE, RUN} stateT;

    stateT               state;
    logic [DATA_W-1:0]   multiplicand;
    logic [DATA_W-1:0]   multiplier;
    logic [DATA_W-1:0]   acc;
    logic [3:0]          count;
    logic [TAG_W-1:0]    tag;
    logic [3:0]          op;
    logic [TAG_W-1:0]    rob;
    logic [DATA_W-1:0]   valueA;
    logic [DATA_W-1:0]   valueB;
    logic [DATA_W-1:0]   result;
    logic [DATA_W-1:0]   accNext;

    assign op      = inOperation[2*DATA_W+TAG_W+3 -: 4];
    assign rob     = inOperation[2*DATA_W+TAG_W-1 -: TAG_W];
    assign valueA  = inOperation[2*DATA_W-1 -: DATA_W];
    assign valueB  = inOperation[DATA_W-1:0];
    assign accNext = acc + (multiplier[0] ? multiplicand : '0);

    // Single-cycle result for every opcode except MUL
    always_comb begin
        result = '0;
        case (op)
            4'd0: result = valueA + valueB;
            4'd1: result = valueA - valueB;
            4'd2: result = valueA & valueB;
            4'd3: result = valueA | valueB;
            4'd4: result = valueA ^ valueB;
            4'd5: result = valueA << valueB[3:0];
            4'd6: result = valueA >> valueB[3:0];
            4'd8: result = {{(DATA_W-1){1'b0}}, $signed(valueA) < $signed(valueB)};
            default: result = '0;
        endcase
    end

    // Accept ops in IDLE, step the multiplier in RUN; forward is a one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            forward      <= '0;
            count        <= '0;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            tag          <= '0;
        end else begin
            forward <= '0;
            case (state)
                IDLE: if (inOperationValid) begin
                    if (op == 4'd7) begin
                        multiplicand <= valueA;
                        multiplier   <= valueB;
                        acc          <= '0;
                        count        <= '0;
                        tag          <= rob;
                        ready        <= 1'b0;
                        state        <= RUN;
                    end else begin
                        forward <= {1'b1, rob, result};
                    end
                end
                RUN: begin
                    acc          <= accNext;
                    multiplicand <= multiplicand << 1;
                    multiplier   <= multiplier >> 1;
                    count        <= count + 4'd1;
                    if (count == 4'd15) begin
                        forward <= {1'b1, tag, accNext};
                        ready   <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_execution_unit.sv
// tb_execution_unit: scoreboard bench for execution_unit
module tb_execution_unit;
    logic        clk;
    logic        reset;
    logic [41:0] inOperation;
    logic        inOperationValid;
    logic        ready;
    logic [22:0] forward;

    int passCount;
    int checkCount;
    logic [22:0] sb[$];

    execution_unit dut (
        .clk(clk),
        .reset(reset),
        .inOperation(inOperation),
        .inOperationValid(inOperationValid),
        .ready(ready),
        .forward(forward)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else passCount++;
    endtask

    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = a * b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << b[3:0];
            4'd6: return a >> b[3:0];
            4'd7: return p[15:0];
            4'd8: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return 16'd0;
        endcase
    endfunction

    // Compare every forward pulse against the scoreboard; idle bus must be all zero
    always @(negedge clk) begin
        if (forward[22]) begin
            if (sb.size() == 0) check("spurious_pulse", {9'd0, forward}, 32'd0);
            else check("forward", {9'd0, forward}, {9'd0, sb.pop_front()});
        end else begin
            check("idle_zero", {9'd0, forward}, 32'd0);
        end
    end

    task automatic sendOp(input logic [3:0] op, input logic [5:0] rob, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        @(negedge clk);
        inOperation = {op, rob, a, b};
        inOperationValid = 1'b1;
        @(posedge clk);
        sb.push_back({1'b1, rob, exp});
    endtask

    task automatic idleLatency(input string tag);
        @(negedge clk);
        inOperationValid = 1'b0;
        #1 check(tag, sb.size(), 0);
    endtask

    task automatic mulOp(input logic [5:0] rob, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp);
        sendOp(4'd7, rob, a, b, exp);
        #1 inOperation = {4'd0, 6'd40, 16'h1111, 16'h2222};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("mul_busy_ready", ready, 0);
            check("mul_busy_pending", sb.size(), 1);
        end
        @(negedge clk);
        inOperationValid = 1'b0;
        #1;
        check("mul_done_ready", ready, 1);
        check("mul_done_latency", sb.size(), 0);
    endtask

    initial begin
        passCount = 0;
        checkCount = 0;
        reset = 1'b1;
        inOperation = '0;
        inOperationValid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_forward", forward, 0);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("idle_ready", ready, 1);
        end

        // asynchronous reset clears a live pulse without waiting for an edge
        @(negedge clk);
        inOperation = {4'd0, 6'd2, 16'd1, 16'd1};
        inOperationValid = 1'b1;
        @(posedge clk);
        #2 check("pre_async_fwd", forward, {1'b1, 6'd2, 16'd2});
        inOperationValid = 1'b0;
        reset = 1'b1;
        #1 check("async_clear", forward, 0);
        check("async_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0;

        sendOp(4'd0, 6'd5, 16'h7FFF, 16'h0001, 16'h8000);
        idleLatency("add_latency");
        sendOp(4'd1, 6'd63, 16'h0000, 16'h0001, 16'hFFFF);
        idleLatency("sub_latency");

        sendOp(4'd5, 6'd10, 16'h0001, 16'h0011, 16'h0002);
        sendOp(4'd6, 6'd11, 16'h8000, 16'd15, 16'h0001);
        sendOp(4'd8, 6'd12, 16'hFFFF, 16'h0001, 16'h0001);
        sendOp(4'd12, 6'd13, 16'h1234, 16'h5678, 16'h0000);
        idleLatency("b2b_latency");

        mulOp(6'd9, 16'h0123, 16'h0010, 16'h1230);
        mulOp(6'd17, 16'hFFFF, 16'hFFFF, 16'h0001);
        mulOp(6'd33, 16'h00FF, 16'h0101, 16'hFFFF);

        // reset on the 8th RUN cycle discards the multiply
        @(negedge clk);
        inOperation = {4'd7, 6'd20, 16'h0003, 16'h0005};
        inOperationValid = 1'b1;
        @(posedge clk);
        #1 inOperationValid = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        check("mid_run_ready", ready, 1);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("no_stale_pulse", sb.size(), 0);
        sendOp(4'd0, 6'd1, 16'd2, 16'd3, 16'h0005);
        idleLatency("post_reset_add");

        for (int i = 0; i < 24; i++) begin
            logic [3:0] op;
            logic [15:0] a;
            logic [15:0] b;
            logic [5:0] r;
            op = 4'($urandom_range(0, 15));
            if (op == 4'd7) op = 4'd8;
            a = 16'($urandom);
            b = 16'($urandom);
            r = 6'($urandom);
            sendOp(op, r, a, b, model(op, a, b));
        end
        idleLatency("random_drain");
        for (int i = 0; i < 3; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            b = 16'($urandom);
            mulOp(6'(i + 48), a, b, model(4'd7, a, b));
        end

        repeat (3) @(negedge clk);
        check("final_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
